// File: rtl/axi_node_pkg.sv
// Shared definitions for the AXI node B-channel ordering logic.
// Holds the slave-select width, the "no slave" select value and the controller states.
package axi_node_pkg;

   localparam int AXI_SEL_W = 3;

   // A select outside the slave range hits the crossbar default route, so nothing is routed.
   localparam logic [AXI_SEL_W-1:0] B_SEL_NONE = '1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } b_state_t;

endpackage

// File: rtl/b_order_fifo.sv
// In-order FIFO of target-slave indices for outstanding AW transactions.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
module b_order_fifo #(
   parameter  int SEL_W = 3,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [SEL_W-1:0] din,
   input  logic             pop,
   output logic [SEL_W-1:0] head,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [SEL_W-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/b_order_ctrl.sv
// Write-response ordering controller: routes B responses back to the master in AW issue
// order, one at a time, with a hold gap after each completion and an outstanding-write limit.
module b_order_ctrl
   import axi_node_pkg::*;
#(
   parameter  int NUM_SLV  = 5,
   parameter  int SEL_W    = AXI_SEL_W,
   parameter  int DEPTH    = 8,
   parameter  int HOLD_CYC = 2,
   parameter  int TO_W     = 10,
   localparam int CW       = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             aw_fire,
   input  logic [SEL_W-1:0] aw_slv_sel,
   input  logic             m_BVALID,
   input  logic             m_BREADY,
   output logic [SEL_W-1:0] B_SLV_sel,
   output logic             B_hold,
   output logic             aw_stall,
   output logic [CW-1:0]    outstanding,
   output logic             ovf_err,
   output logic             b_timeout
);

   localparam int              HW      = $clog2(HOLD_CYC) + 1;
   localparam logic [SEL_W:0]  SLV_LIM = (SEL_W + 1)'(NUM_SLV);

   b_state_t         state;
   logic [TO_W-1:0]  to_cnt;
   logic [HW-1:0]    hold_cnt;
   logic [SEL_W-1:0] sel_r;
   logic             hold_r;
   logic             ovf_r;
   logic             to_r;

   logic             sel_ok;
   logic             push;
   logic             b_done;
   logic             full;
   logic             empty;
   logic [SEL_W-1:0] head;
   logic [CW-1:0]    count;

   // Full is taken before any same-cycle pop, so a push while full is always rejected.
   assign sel_ok = ({1'b0, aw_slv_sel} < SLV_LIM);
   assign push   = aw_fire && !full && sel_ok;
   assign b_done = m_BVALID && m_BREADY && (state == ST_ACTIVE);

   b_order_fifo #(
      .SEL_W (SEL_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (aw_slv_sel),
      .pop   (b_done),
      .head  (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         sel_r    <= B_SEL_NONE;
         hold_r   <= 1'b1;
         to_cnt   <= '0;
         hold_cnt <= '0;
         ovf_r    <= 1'b0;
         to_r     <= 1'b0;
      end else begin
         ovf_r <= aw_fire && (full || !sel_ok);
         to_r  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (push) begin
                  state  <= ST_ACTIVE;
                  sel_r  <= aw_slv_sel;
                  hold_r <= 1'b0;
                  to_cnt <= '0;
               end
            end
            ST_ACTIVE: begin
               if (b_done) begin
                  state    <= ST_DRAIN;
                  hold_r   <= 1'b1;
                  hold_cnt <= HW'(HOLD_CYC - 1);
                  to_cnt   <= '0;
               end else if (to_cnt == '1) begin
                  to_r   <= 1'b1;
                  to_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (hold_cnt != '0) begin
                  hold_cnt <= hold_cnt - 1'b1;
               end else if (!empty) begin
                  state  <= ST_ACTIVE;
                  sel_r  <= head;
                  hold_r <= 1'b0;
               end else if (push) begin
                  // The FIFO is still empty this cycle, so bypass the entry being written.
                  state  <= ST_ACTIVE;
                  sel_r  <= aw_slv_sel;
                  hold_r <= 1'b0;
               end else begin
                  state <= ST_IDLE;
                  sel_r <= B_SEL_NONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign B_SLV_sel   = sel_r;
   assign B_hold      = hold_r;
   assign aw_stall    = full;
   assign outstanding = count;
   assign ovf_err     = ovf_r;
   assign b_timeout   = to_r;

endmodule

// File: tb/tb_b_order_ctrl.sv
// Bench for b_order_ctrl: directed scenarios followed by random traffic, all checked every
// cycle against a queue-based model of the in-order response rules.
module tb_b_order_ctrl;

   localparam int NUM_SLV  = 5;
   localparam int DEPTH    = 8;
   localparam int HOLD_CYC = 2;
   localparam int TO_W     = 10;
   localparam int TO_MAX   = (1 << TO_W) - 1;

   logic       clk;
   logic       reset;
   logic       aw_fire;
   logic [2:0] aw_slv_sel;
   logic       m_BVALID;
   logic       m_BREADY;
   logic [2:0] B_SLV_sel;
   logic       B_hold;
   logic       aw_stall;
   logic [3:0] outstanding;
   logic       ovf_err;
   logic       b_timeout;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: queue of slaves awaiting a response, whether one is being routed, hold gap left.
   int q[$];
   bit m_route;
   int m_gap;
   int m_sel;
   int m_to;
   bit m_ovf;
   bit m_tout;

   b_order_ctrl #(
      .NUM_SLV  (NUM_SLV),
      .SEL_W    (3),
      .DEPTH    (DEPTH),
      .HOLD_CYC (HOLD_CYC),
      .TO_W     (TO_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .aw_fire     (aw_fire),
      .aw_slv_sel  (aw_slv_sel),
      .m_BVALID    (m_BVALID),
      .m_BREADY    (m_BREADY),
      .B_SLV_sel   (B_SLV_sel),
      .B_hold      (B_hold),
      .aw_stall    (aw_stall),
      .outstanding (outstanding),
      .ovf_err     (ovf_err),
      .b_timeout   (b_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic void model_reset();
      q.delete();
      m_route = 1'b0;
      m_gap   = 0;
      m_sel   = 7;
      m_to    = 0;
      m_ovf   = 1'b0;
      m_tout  = 1'b0;
   endfunction

   function automatic void model_step(bit fire, int s, bit bv, bit br);
      bit full, done, push;
      full   = (q.size() == DEPTH);
      done   = bv && br && m_route;
      push   = fire && !full && (s < NUM_SLV);
      m_ovf  = fire && (full || s >= NUM_SLV);
      m_tout = 1'b0;
      if (done) void'(q.pop_front());
      if (push) q.push_back(s);
      if (m_route) begin
         if (done) begin
            m_route = 1'b0;
            m_gap   = HOLD_CYC;
            m_to    = 0;
         end else if (m_to == TO_MAX) begin
            m_tout = 1'b1;
            m_to   = 0;
         end else begin
            m_to++;
         end
      end else if (m_gap > 0) begin
         m_gap--;
         if (m_gap == 0) begin
            if (q.size() > 0) begin
               m_route = 1'b1;
               m_sel   = q[0];
            end else begin
               m_sel = 7;
            end
         end
      end else if (q.size() > 0) begin
         m_route = 1'b1;
         m_sel   = q[0];
      end
   endfunction

   task automatic check_all();
      check("sel",   B_SLV_sel,   m_sel);
      check("hold",  B_hold,      int'(!m_route));
      check("outst", outstanding, q.size());
      check("stall", aw_stall,    int'(q.size() == DEPTH));
      check("ovf",   ovf_err,     int'(m_ovf));
      check("tout",  b_timeout,   int'(m_tout));
   endtask

   task automatic cycle(input bit fire, input int s, input bit bv, input bit br);
      aw_fire    = fire;
      aw_slv_sel = 3'(s);
      m_BVALID   = bv;
      m_BREADY   = br;
      @(posedge clk);
      model_step(fire, s, bv, br);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      aw_fire  = 1'b0;
      m_BVALID = 1'b0;
      m_BREADY = 1'b0;
      @(posedge clk);
      model_reset();
      #1;
      check_all();
      reset = 1'b0;
   endtask

   initial begin
      int got[$];
      int fsel[8];
      int pulses;
      int budget;

      reset      = 1'b1;
      aw_fire    = 1'b0;
      aw_slv_sel = '0;
      m_BVALID   = 1'b0;
      m_BREADY   = 1'b0;
      model_reset();
      do_reset();
      check("rst_sel", B_SLV_sel, 7);
      check("rst_hold", B_hold, 1);

      // Single write to slave 2, completed four cycles later.
      cycle(1, 2, 0, 0);
      check("sw_sel", B_SLV_sel, 2);
      check("sw_hold", B_hold, 0);
      repeat (3) cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 1);
      cycle(0, 0, 0, 0);
      check("sw_gap1", B_hold, 1);
      cycle(0, 0, 0, 0);
      check("sw_gap2", B_hold, 1);
      cycle(0, 0, 0, 0);
      check("sw_idle_sel", B_SLV_sel, 7);
      check("sw_idle_out", outstanding, 0);

      // Ordering across three slaves.
      cycle(1, 3, 0, 1);
      check("ord_out1", outstanding, 1);
      cycle(1, 0, 0, 1);
      check("ord_out2", outstanding, 2);
      cycle(1, 4, 0, 1);
      check("ord_out3", outstanding, 3);
      got.delete();
      for (int i = 0; i < 30; i++) begin
         if (!B_hold) got.push_back(int'(B_SLV_sel));
         cycle(0, 0, !B_hold, 1);
      end
      check("ord_n", got.size(), 3);
      if (got.size() == 3) begin
         check("ord_0", got[0], 3);
         check("ord_1", got[1], 0);
         check("ord_2", got[2], 4);
      end

      // Fill to the limit, then overflow.
      fsel = '{4, 3, 2, 0, 4, 3, 2, 0};
      for (int i = 0; i < 8; i++) cycle(1, fsel[i], 0, 0);
      check("full_stall", aw_stall, 1);
      check("full_out", outstanding, 8);
      cycle(1, 2, 0, 0);
      check("full_ovf", ovf_err, 1);
      check("full_out9", outstanding, 8);
      cycle(0, 0, 1, 1);
      check("full_unstall", aw_stall, 0);

      // Drain to three entries, then push and pop in the same cycle.
      budget = 0;
      while (outstanding != 3 && budget < 100) begin
         cycle(0, 0, !B_hold, 1);
         budget++;
      end
      check("pp_reach3", outstanding, 3);
      budget = 0;
      while (B_hold && budget < 20) begin
         cycle(0, 0, 0, 1);
         budget++;
      end
      check("pp_active", B_hold, 0);
      cycle(1, 1, 1, 1);
      check("pp_out", outstanding, 3);
      got.delete();
      for (int i = 0; i < 40; i++) begin
         if (!B_hold) got.push_back(int'(B_SLV_sel));
         cycle(0, 0, !B_hold, 1);
      end
      check("pp_n", got.size(), 3);
      if (got.size() == 3) begin
         check("pp_0", got[0], 2);
         check("pp_1", got[1], 0);
         check("pp_last", got[2], 1);
      end

      // Illegal select is flagged and not queued.
      cycle(1, 5, 0, 0);
      check("ill_ovf", ovf_err, 1);
      check("ill_out", outstanding, 0);
      check("ill_hold", B_hold, 1);

      // Timeout while the head response never arrives.
      cycle(1, 2, 0, 0);
      pulses = 0;
      for (int i = 0; i < 1100; i++) begin
         cycle(0, 0, 0, 1);
         if (b_timeout) pulses++;
      end
      check("to_pulses", pulses, 1);
      check("to_sel", B_SLV_sel, 2);
      check("to_out", outstanding, 1);

      // Reset with four outstanding.
      cycle(1, 0, 0, 0);
      cycle(1, 1, 0, 0);
      cycle(1, 3, 0, 0);
      check("rm_out4", outstanding, 4);
      do_reset();
      check("rm_hold", B_hold, 1);
      check("rm_sel", B_SLV_sel, 7);
      check("rm_out", outstanding, 0);
      check("rm_stall", aw_stall, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            do_reset();
         end else begin
            cycle(($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4)),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 2) != 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
